// File: rtl/sram22_rr_port_arbiter.sv
// Round-robin arbiter sharing one single-port sram22 macro between NUM_REQ requesters,
// with an optional post-reset zero-fill of the array.
module sram22_rr_port_arbiter #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 9,
    parameter int WMASK_WIDTH    = 1,
    parameter int NUM_REQ        = 2,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_REQ-1:0]               req_valid,
    output logic [NUM_REQ-1:0]               req_ready,
    input  logic [NUM_REQ-1:0]               req_we,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]    req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_wdata,
    output logic [NUM_REQ-1:0]               rsp_valid,
    output logic [DATA_WIDTH-1:0]            rsp_rdata,
    output logic                             init_done,
    output logic                             sram_we,
    output logic [WMASK_WIDTH-1:0]           sram_wmask,
    output logic [ADDR_WIDTH-1:0]            sram_addr,
    output logic [DATA_WIDTH-1:0]            sram_din,
    input  logic [DATA_WIDTH-1:0]            sram_dout
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

    typedef enum logic {
        ST_CLEAR,
        ST_RUN
    } state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   clr_cnt_q, clr_cnt_d;
    logic [PTR_W-1:0]        rr_ptr_q, rr_ptr_d;
    logic [NUM_REQ-1:0]      rsp_valid_q, rsp_valid_d;
    logic                    init_done_q, init_done_d;

    logic [2*NUM_REQ-1:0]    valid_rot;
    logic [NUM_REQ-1:0]      grant;
    logic                    grant_any;
    int unsigned             grant_off;
    int unsigned             grant_pos;
    int unsigned             next_pos;

    // Rotate the valid vector so bit 0 is the requester the pointer favours,
    // pick the first set bit, then map the offset back to a requester index.
    always_comb begin
        valid_rot = {req_valid, req_valid} >> rr_ptr_q;
        grant_any = 1'b0;
        grant_off = 0;
        grant     = '0;
        for (int off = 0; off < NUM_REQ; off++) begin
            if (!grant_any && valid_rot[off]) begin
                grant_any = 1'b1;
                grant_off = off;
            end
        end
        grant_pos = int'(rr_ptr_q) + grant_off;
        if (grant_pos >= NUM_REQ) begin
            grant_pos = grant_pos - NUM_REQ;
        end
        next_pos = grant_pos + 1;
        if (next_pos >= NUM_REQ) begin
            next_pos = 0;
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_any && (grant_pos == i)) begin
                grant[i] = 1'b1;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        clr_cnt_d   = clr_cnt_q;
        rr_ptr_d    = rr_ptr_q;
        rsp_valid_d = '0;
        init_done_d = init_done_q;
        req_ready   = '0;
        sram_we     = 1'b0;
        sram_wmask  = '1;
        sram_addr   = '0;
        sram_din    = '0;

        case (state_q)
            ST_CLEAR: begin
                sram_we   = 1'b1;
                sram_addr = clr_cnt_q;
                clr_cnt_d = clr_cnt_q + ADDR_WIDTH'(1);
                if (clr_cnt_q == LAST_ADDR) begin
                    state_d     = ST_RUN;
                    init_done_d = 1'b1;
                end
            end
            ST_RUN: begin
                req_ready = grant;
                for (int i = 0; i < NUM_REQ; i++) begin
                    if (grant[i]) begin
                        sram_we   = req_we[i];
                        sram_addr = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                        sram_din  = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
                    end
                end
                if (grant_any) begin
                    rr_ptr_d    = PTR_W'(next_pos);
                    rsp_valid_d = grant & ~req_we;
                end
            end
            default: begin
                state_d = ST_CLEAR;
            end
        endcase

        // Nothing may reach the macro or a requester while reset is held.
        if (rst) begin
            req_ready = '0;
            sram_we   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;
            clr_cnt_q   <= '0;
            rr_ptr_q    <= '0;
            rsp_valid_q <= '0;
            init_done_q <= (CLEAR_ON_RESET == 0);
        end else begin
            state_q     <= state_d;
            clr_cnt_q   <= clr_cnt_d;
            rr_ptr_q    <= rr_ptr_d;
            rsp_valid_q <= rsp_valid_d;
            init_done_q <= init_done_d;
        end
    end

    // A response still in flight when reset rises is dropped, never shown.
    assign rsp_valid = rst ? '0 : rsp_valid_q;
    assign rsp_rdata = sram_dout;
    assign init_done = init_done_q;

endmodule
